alu_share_arbiter: RTL and testbench

Shares one combinational 32-bit ALU (opcodes AND=0, OR=1, NOR=2, ADD=3, SUB=4, SLL=5, SRL=6) between two requesters, e.g. the main datapath and an address/branch helper. It accepts operations through valid/ready handshakes and arbitrates round-robin. It drives the ALU from registered operands and returns a registered result plus requester ID over one response channel with backpressure.

---
 rtl/alu_share_arbiter.sv | 125 ++++++++++++
 tb/tb_alu_share_arbiter.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one external combinational ALU between two requesters.
// Operands are registered toward the ALU and the result returns on one response channel.
module alu_share_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 4,
  parameter int MAX_OP     = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [OP_WIDTH-1:0]   req0_op,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,
  input  logic [4:0]            req0_shamt,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [OP_WIDTH-1:0]   req1_op,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,
  input  logic [4:0]            req1_shamt,
  output logic [OP_WIDTH-1:0]   alu_op,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [4:0]            alu_shamt,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_zero,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  rsp_zero,
  output logic                  rsp_err,
  output logic [1:0]            dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;
  localparam logic [OP_WIDTH-1:0] MAX_OP_C = OP_WIDTH'(MAX_OP);

  logic [1:0]            r_state;
  logic                  r_last_grant;
  logic [OP_WIDTH-1:0]   r_alu_op;
  logic [DATA_WIDTH-1:0] r_alu_a;
  logic [DATA_WIDTH-1:0] r_alu_b;
  logic [4:0]            r_alu_shamt;
  logic                  r_rsp_valid;
  logic                  r_rsp_id;
  logic [DATA_WIDTH-1:0] r_rsp_result;
  logic                  r_rsp_zero;
  logic                  r_rsp_err;

  logic w_grant0;
  logic w_grant1;
  logic w_idle;

  // A lone valid always wins; on contention the requester not served last wins.
  assign w_grant0 = req0_valid && (!req1_valid || r_last_grant);
  assign w_grant1 = req1_valid && (!req0_valid || !r_last_grant);
  assign w_idle   = (r_state == S_IDLE);

  assign req0_ready = w_idle && w_grant0;
  assign req1_ready = w_idle && w_grant1;

  assign alu_op     = r_alu_op;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_shamt  = r_alu_shamt;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_result = r_rsp_result;
  assign rsp_zero   = r_rsp_zero;
  assign rsp_err    = r_rsp_err;
  assign dbg_state  = r_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_alu_op     <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_shamt  <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
      r_rsp_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant0 || w_grant1) begin
            r_alu_op     <= w_grant1 ? req1_op    : req0_op;
            r_alu_a      <= w_grant1 ? req1_a     : req0_a;
            r_alu_b      <= w_grant1 ? req1_b     : req0_b;
            r_alu_shamt  <= w_grant1 ? req1_shamt : req0_shamt;
            r_rsp_id     <= w_grant1;
            r_last_grant <= w_grant1;
            r_state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // The ALU has had a full cycle to settle on the registered operands.
          r_rsp_result <= alu_result;
          r_rsp_zero   <= alu_zero;
          r_rsp_err    <= (r_alu_op > MAX_OP_C);
          r_rsp_valid  <= 1'b1;
          r_state      <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: models the shared ALU, drives directed and random
// traffic, and scores responses against an operation-level reference model.
module tb_alu_share_arbiter;
  localparam int W  = 32;
  localparam int EW = W + 3;
  localparam int RW = 4 + W + W + 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]    req0_op, req1_op, alu_op;
  logic [W-1:0]  req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_result, rsp_result;
  logic [4:0]    req0_shamt, req1_shamt, alu_shamt;
  logic          alu_zero, rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;
  logic [1:0]    dbg_state;

  int            checks = 0;
  int            failures = 0;
  logic          tb_last;
  logic [EW-1:0] exp_q[$];
  logic [RW-1:0] q0[$];
  logic [RW-1:0] q1[$];
  logic          gq[$];

  alu_share_arbiter #(.DATA_WIDTH(W), .OP_WIDTH(4), .MAX_OP(6)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b), .req0_shamt(req0_shamt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_shamt(req1_shamt),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu_fn(input logic [3:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic [4:0] sh);
    case (op)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return ~(a | b);
      4'd3:    return a + b;
      4'd4:    return a - b;
      4'd5:    return b << sh;
      4'd6:    return b >> sh;
      default: return '0;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_op, alu_a, alu_b, alu_shamt);
  assign alu_zero   = (alu_result == '0);

  function automatic logic [RW-1:0] mk(input logic [3:0] op, input logic [W-1:0] a,
                                       input logic [W-1:0] b, input logic [4:0] sh);
    return {op, a, b, sh};
  endfunction

  // Expected response word {err, zero, id, result} for one operation.
  function automatic logic [EW-1:0] model(input logic [RW-1:0] e, input logic id);
    logic [3:0]   op;
    logic [W-1:0] a, b, r;
    logic [4:0]   sh;
    {op, a, b, sh} = e;
    r = alu_fn(op, a, b, sh);
    return {(op > 4'd6), (r == '0), id, r};
  endfunction

  function automatic logic [EW-1:0] got_rsp();
    return {rsp_err, rsp_zero, rsp_id, rsp_result};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int idx, input logic v, input logic [RW-1:0] e);
    if (idx == 0) begin
      req0_valid = v;
      {req0_op, req0_a, req0_b, req0_shamt} = e;
    end else begin
      req1_valid = v;
      {req1_op, req1_a, req1_b, req1_shamt} = e;
    end
  endtask

  task automatic wait_rsp(input int max_cyc, output int n);
    n = -1;
    for (int i = 1; i <= max_cyc; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(0, 1'b0, '0);
    drive(1, 1'b0, '0);
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready, rsp_valid} !== 3'b000) begin
      failures++;
      $display("FAIL reset_handshake: got %b exp 000", {req0_ready, req1_ready, rsp_valid});
    end
    checks++;
    if ({alu_op, alu_a, alu_b, alu_shamt} !== '0) begin
      failures++;
      $display("FAIL reset_alu: got op=%h a=%h b=%h sh=%h exp all 0", alu_op, alu_a, alu_b, alu_shamt);
    end
    checks++;
    if (got_rsp() !== '0) begin
      failures++;
      $display("FAIL reset_rsp: got %h exp 0", got_rsp());
    end
    tick();
    reset = 1'b0;
    tb_last = 1'b1;
  endtask

  task automatic test_single_add();
    int n;
    drive(0, 1'b1, mk(4'd3, 32'd5, 32'd7, 5'd0));
    @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      failures++;
      $display("FAIL add_ready: got %b exp 10", {req0_ready, req1_ready});
    end
    tick();
    drive(0, 1'b0, '0);
    wait_rsp(6, n);
    checks++;
    if (n != 2) begin
      failures++;
      $display("FAIL add_latency: got %0d exp 2", n);
    end
    checks++;
    if (got_rsp() !== {1'b0, 1'b0, 1'b0, 32'd12}) begin
      failures++;
      $display("FAIL add_rsp: got %h exp %h", got_rsp(), {1'b0, 1'b0, 1'b0, 32'd12});
    end
    checks++;
    if ({alu_op, alu_a, alu_b} !== {4'd3, 32'd5, 32'd7}) begin
      failures++;
      $display("FAIL add_alu_hold: got op=%h a=%h b=%h exp 3/5/7", alu_op, alu_a, alu_b);
    end
    tick();
    tb_last = 1'b0;
  endtask

  task automatic test_sub_zero();
    int n;
    drive(1, 1'b1, mk(4'd4, 32'd9, 32'd9, 5'd0));
    @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      failures++;
      $display("FAIL sub_ready: got %b exp 01", {req0_ready, req1_ready});
    end
    tick();
    drive(1, 1'b0, '0);
    wait_rsp(6, n);
    checks++;
    if (n != 2 || got_rsp() !== {1'b0, 1'b1, 1'b1, 32'd0}) begin
      failures++;
      $display("FAIL sub_rsp: got n=%0d rsp=%h exp n=2 rsp=%h", n, got_rsp(), {1'b0, 1'b1, 1'b1, 32'd0});
    end
    tick();
    tb_last = 1'b1;
  endtask

  // Plays q0/q1 into the DUT and scores every cycle against the operation-level model.
  task automatic run_traffic(input bit rnd, input int max_cyc);
    bit   busy = 1'b0;
    int   acc_cyc = 0;
    int   cyc = 0;
    logic v0, v1, e0, e1, win;
    gq.delete();
    while ((q0.size() > 0 || q1.size() > 0 || busy) && cyc < max_cyc) begin
      v0 = (q0.size() > 0) && (!rnd || $urandom_range(0, 3) != 0);
      v1 = (q1.size() > 0) && (!rnd || $urandom_range(0, 3) != 0);
      drive(0, v0, v0 ? q0[0] : '0);
      drive(1, v1, v1 ? q1[0] : '0);
      rsp_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(negedge clk);
      win = (v0 && v1) ? ~tb_last : v1;
      e0 = !busy && (v0 || v1) && !win;
      e1 = !busy && (v0 || v1) && win;
      checks++;
      if ({req0_ready, req1_ready} !== {e0, e1}) begin
        failures++;
        $display("FAIL traffic_ready cyc=%0d: got %b exp %b", cyc, {req0_ready, req1_ready}, {e0, e1});
      end
      checks++;
      if (rsp_valid !== (busy && (cyc - acc_cyc >= 2))) begin
        failures++;
        $display("FAIL traffic_rsp_valid cyc=%0d: got %b exp %b", cyc, rsp_valid, busy && (cyc - acc_cyc >= 2));
      end
      if (rsp_valid === 1'b1 && exp_q.size() > 0) begin
        checks++;
        if (got_rsp() !== exp_q[0]) begin
          failures++;
          $display("FAIL traffic_rsp cyc=%0d: got %h exp %h", cyc, got_rsp(), exp_q[0]);
        end
      end
      if (busy && rsp_valid === 1'b1 && rsp_ready) begin
        void'(exp_q.pop_front());
        busy = 1'b0;
      end else if (e0 || e1) begin
        exp_q.push_back(model(e1 ? q1[0] : q0[0], e1));
        if (e1) void'(q1.pop_front());
        else void'(q0.pop_front());
        busy = 1'b1;
        acc_cyc = cyc;
        tb_last = e1;
        gq.push_back(e1);
      end
      tick();
      cyc++;
    end
    if (cyc >= max_cyc) begin
      checks++;
      failures++;
      $display("FAIL traffic_timeout: got %0d cycles exp < %0d", cyc, max_cyc);
    end
    drive(0, 1'b0, '0);
    drive(1, 1'b0, '0);
    rsp_ready = 1'b1;
    exp_q.delete();
    q0.delete();
    q1.delete();
  endtask

  task automatic test_alternate();
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mk(4'd0, 32'h0000F0F0 | (32'(i) << 16), 32'h0000FF00, 5'd0));
      q1.push_back(mk(4'd1, 32'h00000F0F | (32'(i) << 16), 32'h000000F0, 5'd0));
    end
    run_traffic(1'b0, 200);
    checks++;
    if (gq.size() != 8) begin
      failures++;
      $display("FAIL alt_count: got %0d exp 8", gq.size());
    end
    for (int i = 0; i < gq.size(); i++) begin
      checks++;
      if (gq[i] !== (i % 2 == 1)) begin
        failures++;
        $display("FAIL alt_order[%0d]: got %b exp %b", i, gq[i], (i % 2 == 1));
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    logic [EW-1:0] held;
    rsp_ready = 1'b0;
    drive(0, 1'b1, mk(4'd3, 32'd100, 32'd23, 5'd0));
    @(negedge clk);
    tick();
    drive(0, 1'b0, '0);
    wait_rsp(6, n);
    held = {1'b0, 1'b0, 1'b0, 32'd123};
    tick();
    drive(0, 1'b1, mk(4'd5, 32'd0, 32'd3, 5'd4));
    drive(1, 1'b1, mk(4'd4, 32'd50, 32'd8, 5'd0));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({req0_ready, req1_ready, rsp_valid} !== 3'b001 || got_rsp() !== held) begin
        failures++;
        $display("FAIL bp_stall[%0d]: got rdy=%b vld=%b rsp=%h exp 00/1/%h", i,
                 {req0_ready, req1_ready}, rsp_valid, got_rsp(), held);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      failures++;
      $display("FAIL bp_next_grant: got %b exp 01", {req0_ready, req1_ready});
    end
    tick();
    drive(1, 1'b0, '0);
    wait_rsp(6, n);
    checks++;
    if (n != 2 || got_rsp() !== {1'b0, 1'b0, 1'b1, 32'd42}) begin
      failures++;
      $display("FAIL bp_req1_rsp: got n=%0d rsp=%h exp n=2 rsp=%h", n, got_rsp(), {1'b0, 1'b0, 1'b1, 32'd42});
    end
    tick();
    @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      failures++;
      $display("FAIL bp_req0_grant: got %b exp 10", {req0_ready, req1_ready});
    end
    tick();
    drive(0, 1'b0, '0);
    wait_rsp(6, n);
    checks++;
    if (got_rsp() !== {1'b0, 1'b0, 1'b0, 32'd48}) begin
      failures++;
      $display("FAIL bp_req0_rsp: got %h exp %h", got_rsp(), {1'b0, 1'b0, 1'b0, 32'd48});
    end
    tick();
    tb_last = 1'b0;
  endtask

  task automatic test_illegal();
    int n;
    drive(0, 1'b1, mk(4'd9, 32'd3, 32'd4, 5'd0));
    @(negedge clk);
    tick();
    drive(0, 1'b0, '0);
    wait_rsp(6, n);
    checks++;
    if (n != 2 || got_rsp() !== {1'b1, 1'b1, 1'b0, 32'd0}) begin
      failures++;
      $display("FAIL illegal_rsp: got n=%0d rsp=%h exp n=2 rsp=%h", n, got_rsp(), {1'b1, 1'b1, 1'b0, 32'd0});
    end
    tick();
    drive(1, 1'b1, mk(4'd0, 32'd1, 32'd1, 5'd0));
    @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready, rsp_valid} !== 3'b010) begin
      failures++;
      $display("FAIL illegal_back_idle: got %b exp 010", {req0_ready, req1_ready, rsp_valid});
    end
    tick();
    drive(1, 1'b0, '0);
    wait_rsp(6, n);
    checks++;
    if (got_rsp() !== {1'b0, 1'b0, 1'b1, 32'd1}) begin
      failures++;
      $display("FAIL illegal_follow_rsp: got %h exp %h", got_rsp(), {1'b0, 1'b0, 1'b1, 32'd1});
    end
    tick();
    tb_last = 1'b1;
  endtask

  task automatic test_reset_mid();
    int   n;
    logic seen = 1'b0;
    drive(1, 1'b1, mk(4'd2, 32'h0000000F, 32'h000000F0, 5'd0));
    @(negedge clk);
    tick();
    drive(1, 1'b0, '0);
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      seen = seen | rsp_valid;
    end
    tick();
    reset = 1'b0;
    tb_last = 1'b1;
    repeat (3) begin
      @(negedge clk);
      seen = seen | rsp_valid;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_no_rsp: got %b exp 0", seen);
    end
    tick();
    drive(0, 1'b1, mk(4'd3, 32'd1, 32'd2, 5'd0));
    drive(1, 1'b1, mk(4'd3, 32'd3, 32'd4, 5'd0));
    @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      failures++;
      $display("FAIL reset_mid_grant: got %b exp 10", {req0_ready, req1_ready});
    end
    tick();
    drive(0, 1'b0, '0);
    drive(1, 1'b0, '0);
    wait_rsp(6, n);
    checks++;
    if (got_rsp() !== {1'b0, 1'b0, 1'b0, 32'd3}) begin
      failures++;
      $display("FAIL reset_mid_rsp: got %h exp %h", got_rsp(), {1'b0, 1'b0, 1'b0, 32'd3});
    end
    tick();
    tb_last = 1'b0;
  endtask

  task automatic test_random();
    logic [W-1:0] a;
    for (int i = 0; i < 20; i++) begin
      a = $urandom;
      q0.push_back(mk(4'($urandom_range(0, 8)), a, ($urandom_range(0, 3) == 0) ? a : $urandom,
                      5'($urandom_range(0, 31))));
      a = $urandom;
      q1.push_back(mk(4'($urandom_range(0, 8)), a, ($urandom_range(0, 3) == 0) ? a : $urandom,
                      5'($urandom_range(0, 31))));
    end
    run_traffic(1'b1, 3000);
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_sub_zero();
    test_alternate();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
